mul_unit: RTL and testbench

MUL_UNIT -- requirements
Module: mul_unit

---
 rtl/mul_pkg.sv | 14 +
 rtl/mul_datapath.sv | 88 ++++++++
 rtl/mul_unit.sv | 96 +++++++++
 tb/tb_mul_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the shift-add multiplier.
//   state_t       : controller states IDLE / RUN / DONE
//   DEFAULT_WIDTH : default operand width in bits
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/mul_datapath.sv
// Shift-add datapath: magnitude conversion, 2*WIDTH accumulator, shifted
// multiplicand, multiplier shift register and the registered product.
// Optional macro: MUL_UNIT_SIGNED_EN (honour signed_mode).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load            capture operands and clear the accumulator
//   step            consume one multiplier bit (LSB first)
//   finish          last step; latch the final product
//   signed_mode     operands are two's complement (signed build only)
//   op_a, op_b      multiplicand, multiplier
//   product_lsb/msb registered 2*WIDTH product halves
module mul_datapath #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             finish,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] product_lsb,
    output logic [WIDTH-1:0] product_msb
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] result;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               neg;
    logic               neg_in;

    // Magnitudes are WIDTH-bit unsigned, so the most negative operand
    // (e.g. 0x80 for WIDTH=8) is represented exactly.
    always_comb begin
        mag_a  = op_a;
        mag_b  = op_b;
        neg_in = 1'b0;
`ifdef MUL_UNIT_SIGNED_EN
        if (signed_mode) begin
            if (op_a[WIDTH-1]) mag_a = '0 - op_a;
            if (op_b[WIDTH-1]) mag_b = '0 - op_b;
            neg_in = op_a[WIDTH-1] ^ op_b[WIDTH-1];
        end
`endif
    end

`ifndef MUL_UNIT_SIGNED_EN
    logic signed_mode_unused;
    assign signed_mode_unused = signed_mode;
`endif

    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
        result   = neg ? ('0 - acc_next) : acc_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            neg         <= 1'b0;
            product_lsb <= '0;
            product_msb <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            neg    <= neg_in;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            // The last add is folded into the product register so the
            // result is visible in the DONE cycle itself.
            if (finish) begin
                product_lsb <= result[WIDTH-1:0];
                product_msb <= result[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule

// File: rtl/mul_unit.sv
// Sequential shift-add multiplier, WIDTH RUN cycles per product.
// Optional macro: MUL_UNIT_SIGNED_EN (two's-complement via signed_mode).
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           request a multiply (accepted in IDLE or DONE)
//   signed_mode     operands are two's complement; sampled with start
//   op_a, op_b      multiplicand, multiplier; sampled with start
//   busy            high during RUN
//   done            one-cycle pulse, product valid
//   product_lsb/msb low/high halves of the 2*WIDTH product
module mul_unit
    import mul_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_lsb,
    output logic [WIDTH-1:0] product_msb
);

    localparam int unsigned    CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic          load;
    logic          step;
    logic          finish;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= (state == RUN) ? cnt + CW'(1) : '0;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (cnt == LAST) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = RUN;
                    load       = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    mul_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .step        (step),
        .finish      (finish),
        .signed_mode (signed_mode),
        .op_a        (op_a),
        .op_b        (op_b),
        .product_lsb (product_lsb),
        .product_msb (product_msb)
    );

endmodule

// File: tb/tb_mul_unit.sv
// Directed testbench for mul_unit with WIDTH=8.
// Cycle numbering: cycle 1 is the cycle right after the accepting edge;
// the DONE cycle is cycle 9.
module tb_mul_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       signed_mode;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic       busy;
    logic       done;
    logic [7:0] product_lsb;
    logic [7:0] product_msb;

    int errors = 0;
    int checks = 0;

    mul_unit #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (busy),
        .done        (done),
        .product_lsb (product_lsb),
        .product_msb (product_msb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then count cycles until done (bounded).
    // lat = 0 means done never arrived within the bound.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic sm, output int lat);
        op_a = a; op_b = b; signed_mode = sm; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        if (!done) lat = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; op_a = '0; op_b = '0;
        tick(); tick();
        checks++;
        if ({busy, done, product_msb, product_lsb} !== 18'h0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b prod=%h%h, want 0 0 0000",
                     busy, done, product_msb, product_lsb);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        do_op(8'd5, 8'd6, 1'b0, lat);
        checks++;
        if (lat !== 9) begin
            errors++; $display("FAIL basic_latency: got %0d want 9", lat);
        end
        checks++;
        if ({busy, product_msb, product_lsb} !== {1'b0, 16'h001E}) begin
            errors++;
            $display("FAIL basic_product: busy=%b prod=%h%h want busy=0 001e",
                     busy, product_msb, product_lsb);
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++; $display("FAIL done_pulse_width: busy=%b done=%b want 0 0", busy, done);
        end
        tick(); tick();
        checks++;
        if ({product_msb, product_lsb} !== 16'h001E) begin
            errors++; $display("FAIL product_hold: got %h%h want 001e", product_msb, product_lsb);
        end
    endtask

    task automatic test_all_ones();
        int lat;
        do_op(8'hFF, 8'hFF, 1'b0, lat);
        checks++;
        if (lat !== 9 || {product_msb, product_lsb} !== 16'hFE01) begin
            errors++;
            $display("FAIL all_ones: lat=%0d prod=%h%h want 9 fe01", lat, product_msb, product_lsb);
        end
        tick();
    endtask

    task automatic test_signed();
        int lat;
        logic [15:0] exp1, exp2;
`ifdef MUL_UNIT_SIGNED_EN
        exp1 = 16'hFFF1;   // -3 * 5 = -15
        exp2 = 16'h0080;   // -128 * -1 = 128
`else
        exp1 = 16'h04F1;   // 253 * 5 = 1265
        exp2 = 16'h7F80;   // 128 * 255 = 32640
`endif
        do_op(8'hFD, 8'h05, 1'b1, lat);
        checks++;
        if (lat !== 9 || {product_msb, product_lsb} !== exp1) begin
            errors++;
            $display("FAIL signed_fd_x_5: lat=%0d prod=%h%h want 9 %h", lat, product_msb, product_lsb, exp1);
        end
        tick();
        do_op(8'h80, 8'hFF, 1'b1, lat);
        checks++;
        if (lat !== 9 || {product_msb, product_lsb} !== exp2) begin
            errors++;
            $display("FAIL signed_80_x_ff: lat=%0d prod=%h%h want 9 %h", lat, product_msb, product_lsb, exp2);
        end
        signed_mode = 1'b0;
        tick();
    endtask

    // start held for 20 accepting opportunities: operations complete in
    // cycles 9, 18 and 27 with RUN in every other cycle up to 26.
    task automatic test_back_to_back();
        logic exp_done, exp_busy;
        op_a = 8'd7; op_b = 8'd3; signed_mode = 1'b0; start = 1'b1;
        tick();
        for (int c = 1; c <= 28; c++) begin
            if (c == 20) start = 1'b0;
            exp_done = (c % 9 == 0);
            exp_busy = !exp_done && (c < 27);
            checks++;
            if ({busy, done} !== {exp_busy, exp_done}) begin
                errors++;
                $display("FAIL b2b_handshake cycle %0d: busy=%b done=%b want %b %b",
                         c, busy, done, exp_busy, exp_done);
            end
            if (exp_done) begin
                checks++;
                if ({product_msb, product_lsb} !== 16'd21) begin
                    errors++;
                    $display("FAIL b2b_product cycle %0d: got %h%h want 0015",
                             c, product_msb, product_lsb);
                end
            end
            if (c < 28) tick();
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        op_a = 8'd9; op_b = 8'd9; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();   // now in the 4th RUN cycle
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, product_msb, product_lsb} !== 18'h0) begin
            errors++;
            $display("FAIL mid_reset_clear: busy=%b done=%b prod=%h%h want 0 0 0000",
                     busy, done, product_msb, product_lsb);
        end
        tick();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            if (done || busy) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++; $display("FAIL mid_reset_no_done: activity cycles=%0d want 0", seen);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;   // start is presented for the very first edge after release
        do_op(8'd2, 8'd2, 1'b0, lat);
        checks++;
        if (lat !== 9 || {product_msb, product_lsb} !== 16'd4) begin
            errors++;
            $display("FAIL post_reset_2x2: lat=%0d prod=%h%h want 9 0004", lat, product_msb, product_lsb);
        end
        tick();
    endtask

    // Operands and a stray start change during RUN must not disturb the result.
    task automatic test_zero_hold();
        int lat;
        op_a = 8'h00; op_b = 8'h80; signed_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        op_a = 8'hFF; op_b = 8'hFF; signed_mode = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 3;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (!done || lat !== 9 || {product_msb, product_lsb} !== 16'h0000) begin
            errors++;
            $display("FAIL zero_ignore_changes: done=%b lat=%0d prod=%h%h want 1 9 0000",
                     done, lat, product_msb, product_lsb);
        end
        tick();
        checks++;
        if ({busy, done, product_msb, product_lsb} !== 18'h0) begin
            errors++;
            $display("FAIL zero_back_idle: busy=%b done=%b prod=%h%h want 0 0 0000",
                     busy, done, product_msb, product_lsb);
        end
        signed_mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_ones();
        test_signed();
        test_back_to_back();
        test_reset_mid();
        test_zero_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
